mem_port_arbiter: RTL and testbench

- Shares one single-ported 16-bit memory between the CPU's instruction side (fetch / I-cache refill) and data side (load/store / D-cache refill and writeback).
- Each granted request moves one aligned block of BLOCK_WORDS words as a sequence of single-word memory handshakes.
- Sits between the datapath's two memory ports and the memory model.
- Fixed D-over-I priority, with a streak limit that prevents instruction starvation.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/arb_priority_sel.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE    = 16;
  localparam int BLOCK_WORDS  = 4;
  localparam int MAX_D_STREAK = 2;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_XFER = 2'd1;
  localparam arb_state_t ARB_DONE = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Width of a word index inside a block; a one-word block still needs a 1-bit index.
  function automatic int idxWidth(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Grant decision for the two requesters: data side wins unless it has already
// taken MAX_D_STREAK blocks in a row while the instruction side was waiting.
module arb_priority_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = mem_port_arbiter_pkg::MAX_D_STREAK
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic grant_en,
  output logic grant_i,
  output logic grant_d
);

  localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          d_allowed;

  assign d_allowed = !i_req || (streak_q < STREAK_MAX);
  assign grant_d   = grant_en && d_req && d_allowed;
  assign grant_i   = grant_en && i_req && !grant_d;

  // Count consecutive data grants that bypassed a waiting instruction request.
  always_comb begin
    streak_d = streak_q;
    if (grant_d) begin
      if (!i_req) begin
        streak_d = '0;
      end else if (streak_q < STREAK_MAX) begin
        streak_d = streak_q + SW'(1);
      end
    end else if (grant_i) begin
      streak_d = '0;
    end
  end

  // Streak register.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction and data sides,
// moving one aligned block per grant as a sequence of word handshakes.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE    = mem_port_arbiter_pkg::WORD_SIZE,
  parameter int BLOCK_WORDS  = mem_port_arbiter_pkg::BLOCK_WORDS,
  parameter int MAX_D_STREAK = mem_port_arbiter_pkg::MAX_D_STREAK
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_req,
  input  logic [WORD_SIZE-1:0]             i_addr,
  output logic [BLOCK_WORDS*WORD_SIZE-1:0] i_rdata,
  output logic                             i_done,
  input  logic                             d_req,
  input  logic                             d_we,
  input  logic [WORD_SIZE-1:0]             d_addr,
  input  logic [BLOCK_WORDS*WORD_SIZE-1:0] d_wdata,
  output logic [BLOCK_WORDS*WORD_SIZE-1:0] d_rdata,
  output logic                             d_done,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [WORD_SIZE-1:0]             mem_addr,
  output logic [WORD_SIZE-1:0]             mem_wdata,
  input  logic [WORD_SIZE-1:0]             mem_rdata,
  input  logic                             mem_ack,
  output logic                             busy
);

  localparam int IW      = idxWidth(BLOCK_WORDS);
  localparam int BLK_W   = BLOCK_WORDS * WORD_SIZE;
  localparam logic [WORD_SIZE-1:0] LOW_MASK = WORD_SIZE'(BLOCK_WORDS - 1);
  localparam logic [IW-1:0]        LAST_IDX = IW'(BLOCK_WORDS - 1);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic [WORD_SIZE-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic [BLK_W-1:0]  wdata_q, wdata_d;
  logic [BLK_W-1:0]  i_rdata_q, i_rdata_d;
  logic [BLK_W-1:0]  d_rdata_q, d_rdata_d;
  logic [IW-1:0]     idx_q, idx_d;

  logic grant_en, grant_i, grant_d;
  logic owner_writes;

  assign grant_en     = (state_q == ARB_IDLE);
  assign owner_writes = (owner_q == OWN_D) && we_q;

  arb_priority_sel #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_sel (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .d_req   (d_req),
    .grant_en(grant_en),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  // Next-state: latch the winner's block at grant, step words on ack, pulse done.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    base_d    = base_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    idx_d     = idx_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          owner_d = OWN_D;
          base_d  = d_addr & ~LOW_MASK;
          we_d    = d_we;
          wdata_d = d_wdata;
          idx_d   = '0;
          state_d = ARB_XFER;
        end else if (grant_i) begin
          owner_d = OWN_I;
          base_d  = i_addr & ~LOW_MASK;
          we_d    = 1'b0;
          idx_d   = '0;
          state_d = ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (mem_ack) begin
          if (!owner_writes) begin
            if (owner_q == OWN_I) begin
              i_rdata_d[int'(idx_q)*WORD_SIZE +: WORD_SIZE] = mem_rdata;
            end else begin
              d_rdata_d[int'(idx_q)*WORD_SIZE +: WORD_SIZE] = mem_rdata;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = ARB_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any block in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_I;
      base_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      base_q    <= base_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      idx_q     <= idx_d;
    end
  end

  assign mem_req   = (state_q == ARB_XFER);
  assign mem_we    = mem_req && owner_writes;
  assign mem_addr  = mem_req ? (base_q | WORD_SIZE'(idx_q)) : '0;
  assign mem_wdata = mem_req ? wdata_q[int'(idx_q)*WORD_SIZE +: WORD_SIZE] : '0;
  assign i_done    = (state_q == ARB_DONE) && (owner_q == OWN_I);
  assign d_done    = (state_q == ARB_DONE) && (owner_q == OWN_D);
  assign busy      = (state_q != ARB_IDLE);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [15:0] i_addr;
  logic [63:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:255];
  logic        memReady = 1'b0;
  int          waitCycles = 0;
  logic        forceAck = 1'b0;
  int          waitCnt = 0;
  logic        doneLog[$];

  mem_port_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_done   (i_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .busy     (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Memory model: word i initially holds 16'hA000 + i; ack after waitCycles.
  assign mem_ack   = mem_req && (forceAck || (waitCnt == waitCycles));
  assign mem_rdata = mem[mem_addr[7:0]];

  // Memory contents and wait-state counter.
  always @(posedge clk) begin
    if (!memReady) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
      memReady <= 1'b1;
    end else if (mem_req && mem_ack) begin
      waitCnt <= 0;
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end else if (mem_req) begin
      waitCnt <= waitCnt + 1;
    end else begin
      waitCnt <= 0;
    end
  end

  // Log every completion pulse in order (1 = data side, 0 = instruction side).
  always @(posedge clk) begin
    if (d_done) doneLog.push_back(1'b1);
    if (i_done) doneLog.push_back(1'b0);
  end

  // Hard stop in case a bounded wait is ever miscounted.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iReq, input logic dReq, input logic dWe,
                               input logic [15:0] iAddr, input logic [15:0] dAddr,
                               input logic [63:0] dWdata);
    i_req   = iReq;
    d_req   = dReq;
    d_we    = dWe;
    i_addr  = iAddr;
    d_addr  = dAddr;
    d_wdata = dWdata;
  endtask

  initial begin
    int logStart;
    int n;
    logic [5:0] order;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 64'h0);
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rstBusy",   64'(busy), 64'(0));
    checkOutput("rstMemReq", 64'(mem_req), 64'(0));
    checkOutput("rstMemWe",  64'(mem_we), 64'(0));
    checkOutput("rstAddr",   64'(mem_addr), 64'(0));
    checkOutput("rstWdata",  64'(mem_wdata), 64'(0));
    checkOutput("rstDone",   64'({i_done, d_done}), 64'(0));
    checkOutput("rstIRdata", i_rdata, 64'h0);
    checkOutput("rstDRdata", d_rdata, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // Zero-wait instruction fetch of block 0x0010
    $display("[TB] instruction fetch, zero wait");
    waitCycles = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0013, 16'h0, 64'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t1Addr", 64'(mem_addr), 64'(16'h0010 + k));
      checkOutput("t1MemReq", 64'(mem_req), 64'(1));
      checkOutput("t1EarlyDone", 64'(i_done), 64'(0));
    end
    @(negedge clk);
    checkOutput("t1IDone", 64'(i_done), 64'(1));
    checkOutput("t1DDone", 64'(d_done), 64'(0));
    checkOutput("t1MemReqDone", 64'(mem_req), 64'(0));
    checkOutput("t1IRdata", i_rdata, 64'hA013_A012_A011_A010);
    i_req = 1'b0;
    @(negedge clk);
    checkOutput("t1Idle", 64'(busy), 64'(0));

    // Data write with two wait cycles per word; inputs change after grant
    $display("[TB] data write, two wait cycles");
    waitCycles = 2;
    logStart = doneLog.size();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0, 16'h0040, 64'h0004_0003_0002_0001);
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 3; w++) begin
        @(negedge clk);
        if (k == 0 && w == 0) begin
          d_wdata = '1;
          d_addr  = 16'h0080;
          d_we    = 1'b0;
        end
        checkOutput("t2MemWe", 64'(mem_we), 64'(1));
        checkOutput("t2Wdata", 64'(mem_wdata), 64'(k + 1));
        checkOutput("t2Addr", 64'(mem_addr), 64'(16'h0040 + k));
      end
    end
    @(negedge clk);
    checkOutput("t2DDone", 64'(d_done), 64'(1));
    checkOutput("t2IDone", 64'(i_done), 64'(0));
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("t2DonePulses", 64'(doneLog.size() - logStart), 64'(1));
    checkOutput("t2DRdata", d_rdata, 64'h0);
    for (int k = 0; k < 4; k++) checkOutput("t2MemContent", 64'(mem[8'h40 + k]), 64'(k + 1));

    // Both requesters held: D, D, I, D, D, I
    $display("[TB] both requests held, streak limit");
    waitCycles = 0;
    logStart = doneLog.size();
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0040, 64'h0);
    n = 0;
    while ((doneLog.size() - logStart) < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 64'h0);
    checkOutput("t3Count", 64'(doneLog.size() - logStart), 64'(6));
    order = '0;
    for (int k = 0; k < 6; k++) begin
      if (logStart + k < doneLog.size()) order[5-k] = doneLog[logStart + k];
    end
    checkOutput("t3Order", 64'(order), 64'(6'b110110));
    checkOutput("t3DRdata", d_rdata, 64'h0004_0003_0002_0001);
    checkOutput("t3IRdata", i_rdata, 64'hA013_A012_A011_A010);
    @(negedge clk);
    checkOutput("t3Idle", 64'(busy), 64'(0));

    // Same-cycle requests from idle: D first, then I; the other rdata holds
    $display("[TB] simultaneous requests from idle");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0030, 64'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t4IHold", i_rdata, 64'hA013_A012_A011_A010);
      checkOutput("t4EarlyDDone", 64'(d_done), 64'(0));
    end
    @(negedge clk);
    checkOutput("t4DDone", 64'(d_done), 64'(1));
    checkOutput("t4IDoneEarly", 64'(i_done), 64'(0));
    checkOutput("t4DRdata", d_rdata, 64'hA033_A032_A031_A030);
    d_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      checkOutput("t4DHold", d_rdata, 64'hA033_A032_A031_A030);
    end while (!i_done && n < 20);
    checkOutput("t4ILatency", 64'(n), 64'(6));
    checkOutput("t4IRdata", i_rdata, 64'hA023_A022_A021_A020);
    i_req = 1'b0;
    @(negedge clk);

    // Reset after the second word ack of a data read
    $display("[TB] reset mid-transfer");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 16'h0050, 64'h0);
    @(negedge clk);
    checkOutput("t5Addr0", 64'(mem_addr), 64'(16'h0050));
    @(negedge clk);
    checkOutput("t5Addr1", 64'(mem_addr), 64'(16'h0051));
    @(negedge clk);
    logStart = doneLog.size();
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("t5MemReq", 64'(mem_req), 64'(0));
    checkOutput("t5Busy", 64'(busy), 64'(0));
    checkOutput("t5DDone", 64'(d_done), 64'(0));
    checkOutput("t5DRdata", d_rdata, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t5NoDone", 64'(doneLog.size() - logStart), 64'(0));
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 16'h0052, 64'h0);
    @(negedge clk);
    checkOutput("t5Restart", 64'(mem_addr), 64'(16'h0050));
    repeat (3) @(negedge clk);
    checkOutput("t5LastAddr", 64'(mem_addr), 64'(16'h0053));
    @(negedge clk);
    checkOutput("t5FreshDone", 64'(d_done), 64'(1));
    checkOutput("t5FreshData", d_rdata, 64'hA053_A052_A051_A050);
    d_req = 1'b0;
    @(negedge clk);

    // mem_ack stuck high; i_req stays high across DONE
    $display("[TB] continuous ack, back-to-back request");
    forceAck = 1'b1;
    logStart = doneLog.size();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0060, 16'h0, 64'h0);
    repeat (5) @(negedge clk);
    checkOutput("t6IDone", 64'(i_done), 64'(1));
    @(negedge clk);
    checkOutput("t6IdleBusy", 64'(busy), 64'(0));
    checkOutput("t6NoDouble", 64'(i_done), 64'(0));
    checkOutput("t6IdleMemReq", 64'(mem_req), 64'(0));
    @(negedge clk);
    checkOutput("t6Regrant", 64'(mem_req), 64'(1));
    checkOutput("t6RegrantAddr", 64'(mem_addr), 64'(16'h0060));
    i_req = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t6SecondDone", 64'(i_done), 64'(1));
    checkOutput("t6IRdata", i_rdata, 64'hA063_A062_A061_A060);
    @(negedge clk);
    checkOutput("t6AfterDone", 64'(i_done), 64'(0));
    checkOutput("t6FinalIdle", 64'(busy), 64'(0));
    @(negedge clk);
    checkOutput("t6DoneCount", 64'(doneLog.size() - logStart), 64'(2));
    forceAck = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
